// File: rtl/mem_access_if.sv
// Memory-side request/response bus of the memory-access stage.
// The unit is the master; the data memory (or its model) is the slave.
interface mem_access_if #(
    parameter int XLEN = 32
) ();
    logic              mem_req;
    logic              mem_we;
    logic [XLEN/8-1:0] mem_be;
    logic [XLEN-1:0]   mem_adr;
    logic [XLEN-1:0]   mem_wdata;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [XLEN-1:0]   mem_rdata;

    modport master (
        output mem_req, mem_we, mem_be, mem_adr, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_be, mem_adr, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// Memory-access / writeback-select stage: sized loads and stores over a
// req/gnt/rvalid bus, with misalignment detection and a bus timeout.
module mem_access_unit #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_in,
    output logic              ready_out,
    input  logic [XLEN-1:0]   rz,
    input  logic [XLEN-1:0]   rm,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [1:0]        mem_size,
    input  logic              mem_unsigned,
    input  logic [1:0]        y_sel,
    input  logic [XLEN-1:0]   ret_ad,
    mem_access_if.master      bus,
    output logic [XLEN-1:0]   ry,
    output logic              ry_valid,
    output logic              done,
    output logic              misalign_err,
    output logic              bus_err
);
    localparam int NB    = XLEN / 8;
    localparam int LSB   = $clog2(NB);
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [LSB-1:0]    lane_reg, lane_next;
    logic [1:0]        size_reg, size_next;
    logic              uns_reg, uns_next;
    logic [1:0]        ysel_reg, ysel_next;
    logic [XLEN-1:0]   rz_reg, rz_next;
    logic [XLEN-1:0]   ret_reg, ret_next;
    logic [XLEN-1:0]   ry_reg, ry_next;
    logic              ry_valid_reg, ry_valid_next;
    logic              done_reg, done_next;
    logic              mis_reg, mis_next;
    logic              berr_reg, berr_next;
    logic              req_reg, req_next;
    logic              we_reg, we_next;
    logic [NB-1:0]     be_reg, be_next;
    logic [XLEN-1:0]   adr_reg, adr_next;
    logic [XLEN-1:0]   wdata_reg, wdata_next;

    logic              is_mem, is_store, misaligned, timeout_hit;
    logic [LSB-1:0]    lane;
    logic [NB-1:0]     be_sel;
    logic [XLEN-1:0]   wdata_b, wdata_h, wdata_w, wdata_sel;
    logic [XLEN-1:0]   rdata_sh, load_ext;

    function automatic logic [XLEN-1:0] wb_mux(input logic [1:0] sel,
                                               input logic [XLEN-1:0] a_rz,
                                               input logic [XLEN-1:0] a_ld,
                                               input logic [XLEN-1:0] a_ret);
        case (sel)
            2'd0:    wb_mux = a_rz;
            2'd1:    wb_mux = a_ld;
            2'd2:    wb_mux = a_ret;
            default: wb_mux = '0;
        endcase
    endfunction

    // Read+write together is an illegal encoding and is executed as a load.
    assign is_mem      = mem_read | mem_write;
    assign is_store    = mem_write & ~mem_read;
    assign lane        = rz[LSB-1:0];
    assign timeout_hit = (TIMEOUT > 0) && (cnt_reg == CNT_LAST);

    always_comb begin
        misaligned = 1'b0;
        case (mem_size)
            2'b01:   misaligned = rz[0];
            2'b10:   misaligned = (rz[1:0] != 2'b00);
            2'b11:   misaligned = (XLEN == 32) || (rz[2:0] != 3'b000);
            default: misaligned = 1'b0;
        endcase
    end

    always_comb begin
        case (mem_size)
            2'b00:   be_sel = NB'(1) << lane;
            2'b01:   be_sel = NB'(3) << lane;
            2'b10:   be_sel = (XLEN == 64) ? (NB'(15) << lane) : '1;
            default: be_sel = '1;
        endcase
    end

    // Store data is replicated into every lane so the memory needs no shifter.
    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_rep_b
            assign wdata_b[8*gi +: 8] = rm[7:0];
        end
        for (gi = 0; gi < NB/2; gi++) begin : g_rep_h
            assign wdata_h[16*gi +: 16] = rm[15:0];
        end
        for (gi = 0; gi < NB/4; gi++) begin : g_rep_w
            assign wdata_w[32*gi +: 32] = rm[31:0];
        end
    endgenerate

    always_comb begin
        case (mem_size)
            2'b00:   wdata_sel = wdata_b;
            2'b01:   wdata_sel = wdata_h;
            2'b10:   wdata_sel = wdata_w;
            default: wdata_sel = rm;
        endcase
    end

    assign rdata_sh = bus.mem_rdata >> {lane_reg, 3'b000};

    always_comb begin
        case (size_reg)
            2'b00:   load_ext = uns_reg ? XLEN'(rdata_sh[7:0])  : XLEN'($signed(rdata_sh[7:0]));
            2'b01:   load_ext = uns_reg ? XLEN'(rdata_sh[15:0]) : XLEN'($signed(rdata_sh[15:0]));
            2'b10:   load_ext = uns_reg ? XLEN'(rdata_sh[31:0]) : XLEN'($signed(rdata_sh[31:0]));
            default: load_ext = rdata_sh;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            cnt_reg      <= '0;
            lane_reg     <= '0;
            size_reg     <= '0;
            uns_reg      <= 1'b0;
            ysel_reg     <= '0;
            rz_reg       <= '0;
            ret_reg      <= '0;
            ry_reg       <= '0;
            ry_valid_reg <= 1'b0;
            done_reg     <= 1'b0;
            mis_reg      <= 1'b0;
            berr_reg     <= 1'b0;
            req_reg      <= 1'b0;
            we_reg       <= 1'b0;
            be_reg       <= '0;
            adr_reg      <= '0;
            wdata_reg    <= '0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            lane_reg     <= lane_next;
            size_reg     <= size_next;
            uns_reg      <= uns_next;
            ysel_reg     <= ysel_next;
            rz_reg       <= rz_next;
            ret_reg      <= ret_next;
            ry_reg       <= ry_next;
            ry_valid_reg <= ry_valid_next;
            done_reg     <= done_next;
            mis_reg      <= mis_next;
            berr_reg     <= berr_next;
            req_reg      <= req_next;
            we_reg       <= we_next;
            be_reg       <= be_next;
            adr_reg      <= adr_next;
            wdata_reg    <= wdata_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: if (valid_in && is_mem && !misaligned) state_next = S_REQ;
            S_REQ: begin
                if (bus.mem_gnt)      state_next = we_reg ? S_IDLE : S_WAIT;
                else if (timeout_hit) state_next = S_IDLE;
            end
            S_WAIT: begin
                if (bus.mem_rvalid || timeout_hit) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        ry_next       = ry_reg;
        ry_valid_next = 1'b0;
        done_next     = 1'b0;
        mis_next      = 1'b0;
        berr_next     = 1'b0;
        req_next      = req_reg;
        we_next       = we_reg;
        be_next       = be_reg;
        adr_next      = adr_reg;
        wdata_next    = wdata_reg;
        lane_next     = lane_reg;
        size_next     = size_reg;
        uns_next      = uns_reg;
        ysel_next     = ysel_reg;
        rz_next       = rz_reg;
        ret_next      = ret_reg;
        cnt_next      = '0;
        case (state_reg)
            S_IDLE: begin
                if (valid_in) begin
                    if (!is_mem) begin
                        ry_next       = wb_mux(y_sel, rz, '0, ret_ad);
                        ry_valid_next = 1'b1;
                        done_next     = 1'b1;
                    end else if (misaligned) begin
                        mis_next  = 1'b1;
                        done_next = 1'b1;
                    end else begin
                        lane_next  = lane;
                        size_next  = mem_size;
                        uns_next   = mem_unsigned;
                        ysel_next  = y_sel;
                        rz_next    = rz;
                        ret_next   = ret_ad;
                        req_next   = 1'b1;
                        we_next    = is_store;
                        be_next    = be_sel;
                        adr_next   = {rz[XLEN-1:LSB], {LSB{1'b0}}};
                        wdata_next = wdata_sel;
                    end
                end
            end
            S_REQ: begin
                if (bus.mem_gnt) begin
                    req_next  = 1'b0;
                    done_next = we_reg;
                end else if (timeout_hit) begin
                    req_next  = 1'b0;
                    berr_next = 1'b1;
                    done_next = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            S_WAIT: begin
                if (bus.mem_rvalid) begin
                    ry_next       = (ysel_reg == 2'd1) ? load_ext
                                                       : wb_mux(ysel_reg, rz_reg, '0, ret_reg);
                    ry_valid_next = 1'b1;
                    done_next     = 1'b1;
                end else if (timeout_hit) begin
                    berr_next = 1'b1;
                    done_next = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign ready_out     = (state_reg == S_IDLE);
    assign ry            = ry_reg;
    assign ry_valid      = ry_valid_reg;
    assign done          = done_reg;
    assign misalign_err  = mis_reg;
    assign bus_err       = berr_reg;
    assign bus.mem_req   = req_reg;
    assign bus.mem_we    = we_reg;
    assign bus.mem_be    = be_reg;
    assign bus.mem_adr   = adr_reg;
    assign bus.mem_wdata = wdata_reg;
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit (XLEN=32, TIMEOUT=4); inputs change and
// outputs are sampled 1 ns after each rising edge.
module tb_mem_access_unit;
    localparam int XLEN = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              valid_in;
    logic              ready_out;
    logic [XLEN-1:0]   rz, rm, ret_ad, ry;
    logic              mem_read, mem_write, mem_unsigned;
    logic [1:0]        mem_size, y_sel;
    logic              ry_valid, done, misalign_err, bus_err;

    int n_cmp = 0;
    int n_err = 0;

    mem_access_if #(.XLEN(XLEN)) bus ();

    mem_access_unit #(.XLEN(XLEN), .TIMEOUT(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .valid_in     (valid_in),
        .ready_out    (ready_out),
        .rz           (rz),
        .rm           (rm),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_size     (mem_size),
        .mem_unsigned (mem_unsigned),
        .y_sel        (y_sel),
        .ret_ad       (ret_ad),
        .bus          (bus),
        .ry           (ry),
        .ry_valid     (ry_valid),
        .done         (done),
        .misalign_err (misalign_err),
        .bus_err      (bus_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        valid_in = 0; rz = '0; rm = '0; ret_ad = '0;
        mem_read = 0; mem_write = 0; mem_unsigned = 0;
        mem_size = 2'b00; y_sel = 2'd0;
        bus.mem_gnt = 0; bus.mem_rvalid = 0; bus.mem_rdata = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        tick();
        tick();
        $display("reset: ry=%h req=%b", ry, bus.mem_req);
        n_cmp++;
        if (ry !== 32'h0) begin
            n_err++; $display("FAIL reset_ry: got %h expected %h", ry, 32'h0);
        end
        n_cmp++;
        if ({ry_valid, done, misalign_err, bus_err, bus.mem_req, bus.mem_we} !== 6'b0) begin
            n_err++; $display("FAIL reset_flags: got %b expected %b",
                              {ry_valid, done, misalign_err, bus_err, bus.mem_req, bus.mem_we}, 6'b0);
        end
        n_cmp++;
        if ({bus.mem_be, bus.mem_adr, bus.mem_wdata} !== 68'h0) begin
            n_err++; $display("FAIL reset_bus: got %h expected 0",
                              {bus.mem_be, bus.mem_adr, bus.mem_wdata});
        end
        n_cmp++;
        if (ready_out !== 1'b1) begin
            n_err++; $display("FAIL reset_ready: got %b expected 1", ready_out);
        end
        rst = 0;
        tick();
    endtask

    task automatic test_alu();
        valid_in = 1; y_sel = 2'd0; rz = 32'h1234_5678;
        tick();
        valid_in = 0;
        $display("alu y_sel=0: ry=%h", ry);
        n_cmp++;
        if (ry !== 32'h1234_5678) begin
            n_err++; $display("FAIL alu_rz_ry: got %h expected %h", ry, 32'h1234_5678);
        end
        n_cmp++;
        if ({ry_valid, done, bus.mem_req, ready_out} !== 4'b1101) begin
            n_err++; $display("FAIL alu_rz_flags: got %b expected %b",
                              {ry_valid, done, bus.mem_req, ready_out}, 4'b1101);
        end
        tick();
        n_cmp++;
        if ({ry_valid, done} !== 2'b00 || ry !== 32'h1234_5678) begin
            n_err++; $display("FAIL alu_hold: got %b/%h expected 00/%h", {ry_valid, done}, ry, 32'h1234_5678);
        end
        valid_in = 1; y_sel = 2'd2; ret_ad = 32'h104;
        tick();
        valid_in = 0;
        $display("alu y_sel=2: ry=%h", ry);
        n_cmp++;
        if (ry !== 32'h104 || ry_valid !== 1'b1) begin
            n_err++; $display("FAIL alu_ret_ry: got %h/%b expected %h/1", ry, ry_valid, 32'h104);
        end
        tick();
    endtask

    task automatic test_load_byte();
        valid_in = 1; mem_read = 1; rz = 32'h1003; mem_size = 2'b00;
        mem_unsigned = 0; y_sel = 2'd1;
        tick();
        valid_in = 0; mem_read = 0; rz = 32'hFFFF_FFFF;
        n_cmp++;
        if ({bus.mem_req, bus.mem_we, bus.mem_be, bus.mem_adr} !== {1'b1, 1'b0, 4'b1000, 32'h1000}) begin
            n_err++; $display("FAIL lb_req: got %b %b %b %h expected 1 0 1000 00001000",
                              bus.mem_req, bus.mem_we, bus.mem_be, bus.mem_adr);
        end
        tick();
        n_cmp++;
        if ({bus.mem_req, ready_out} !== 2'b10 || bus.mem_adr !== 32'h1000) begin
            n_err++; $display("FAIL lb_hold: got req=%b rdy=%b adr=%h expected 1 0 00001000",
                              bus.mem_req, ready_out, bus.mem_adr);
        end
        bus.mem_gnt = 1;
        tick();
        bus.mem_gnt = 0;
        n_cmp++;
        if ({bus.mem_req, ready_out, done} !== 3'b000) begin
            n_err++; $display("FAIL lb_wait: got %b expected 000", {bus.mem_req, ready_out, done});
        end
        bus.mem_rvalid = 1; bus.mem_rdata = 32'h80AA_BBCC;
        tick();
        bus.mem_rvalid = 0;
        $display("load byte signed @1003: ry=%h", ry);
        n_cmp++;
        if (ry !== 32'hFFFF_FF80 || {ry_valid, done, ready_out} !== 3'b111) begin
            n_err++; $display("FAIL lb_result: got %h %b expected ffffff80 111",
                              ry, {ry_valid, done, ready_out});
        end
        tick();
        n_cmp++;
        if ({ry_valid, done} !== 2'b00) begin
            n_err++; $display("FAIL lb_pulse: got %b expected 00", {ry_valid, done});
        end
    endtask

    task automatic test_load_half_unsigned();
        valid_in = 1; mem_read = 1; rz = 32'h1002; mem_size = 2'b01;
        mem_unsigned = 1; y_sel = 2'd1;
        tick();
        valid_in = 0; mem_read = 0;
        n_cmp++;
        if (bus.mem_be !== 4'b1100) begin
            n_err++; $display("FAIL lhu_be: got %b expected 1100", bus.mem_be);
        end
        // rvalid together with gnt must be ignored
        bus.mem_gnt = 1; bus.mem_rvalid = 1; bus.mem_rdata = 32'h1111_2222;
        tick();
        bus.mem_gnt = 0; bus.mem_rvalid = 0;
        n_cmp++;
        if ({ry_valid, done} !== 2'b00) begin
            n_err++; $display("FAIL lhu_early_rvalid: got %b expected 00", {ry_valid, done});
        end
        bus.mem_rvalid = 1; bus.mem_rdata = 32'h80AA_BBCC;
        tick();
        bus.mem_rvalid = 0;
        $display("load half unsigned @1002: ry=%h", ry);
        n_cmp++;
        if (ry !== 32'h0000_80AA || ry_valid !== 1'b1) begin
            n_err++; $display("FAIL lhu_result: got %h/%b expected 000080aa/1", ry, ry_valid);
        end
        tick();
    endtask

    task automatic test_load_ysel_ret();
        // read+write together is executed as a load
        valid_in = 1; mem_read = 1; mem_write = 1; rz = 32'h4000; mem_size = 2'b10;
        mem_unsigned = 0; y_sel = 2'd2; ret_ad = 32'h200;
        tick();
        valid_in = 0; mem_read = 0; mem_write = 0; ret_ad = 32'h999; rz = '0;
        n_cmp++;
        if ({bus.mem_req, bus.mem_we, bus.mem_be} !== 6'b101111) begin
            n_err++; $display("FAIL lwret_req: got %b expected 101111", {bus.mem_req, bus.mem_we, bus.mem_be});
        end
        bus.mem_gnt = 1;
        tick();
        bus.mem_gnt = 0;
        bus.mem_rvalid = 1; bus.mem_rdata = 32'h55;
        tick();
        bus.mem_rvalid = 0;
        $display("load word y_sel=2 @4000: ry=%h", ry);
        n_cmp++;
        if (ry !== 32'h200 || done !== 1'b1) begin
            n_err++; $display("FAIL lwret_result: got %h/%b expected 00000200/1", ry, done);
        end
        tick();
    endtask

    task automatic test_store_half();
        valid_in = 1; mem_write = 1; rz = 32'h2002; rm = 32'hDEAD_BEEF; mem_size = 2'b01;
        tick();
        valid_in = 0; mem_write = 0; rz = 32'h0BAD_0BAD; rm = 32'h1234_5678;
        $display("store half @2002: we=%b be=%b wdata=%h", bus.mem_we, bus.mem_be, bus.mem_wdata);
        n_cmp++;
        if ({bus.mem_req, bus.mem_we, bus.mem_be, bus.mem_adr, bus.mem_wdata}
            !== {1'b1, 1'b1, 4'b1100, 32'h2000, 32'hBEEF_BEEF}) begin
            n_err++; $display("FAIL sh_req: got %b %b %b %h %h expected 1 1 1100 00002000 beefbeef",
                              bus.mem_req, bus.mem_we, bus.mem_be, bus.mem_adr, bus.mem_wdata);
        end
        tick();
        n_cmp++;
        if ({bus.mem_req, bus.mem_be, bus.mem_adr, bus.mem_wdata}
            !== {1'b1, 4'b1100, 32'h2000, 32'hBEEF_BEEF}) begin
            n_err++; $display("FAIL sh_hold: got %b %b %h %h expected 1 1100 00002000 beefbeef",
                              bus.mem_req, bus.mem_be, bus.mem_adr, bus.mem_wdata);
        end
        bus.mem_gnt = 1;
        tick();
        bus.mem_gnt = 0;
        n_cmp++;
        if ({bus.mem_req, done, ry_valid, ready_out} !== 4'b0101 || ry !== 32'h200) begin
            n_err++; $display("FAIL sh_done: got %b ry=%h expected 0101 ry=00000200",
                              {bus.mem_req, done, ry_valid, ready_out}, ry);
        end
        tick();
        n_cmp++;
        if (done !== 1'b0) begin
            n_err++; $display("FAIL sh_pulse: got %b expected 0", done);
        end
    endtask

    task automatic test_store_table();
        logic [31:0] t_adr   [3] = '{32'h2001, 32'h2006, 32'h2004};
        logic [31:0] t_rm    [3] = '{32'h1234_56A5, 32'h0000_7E81, 32'hCAFE_F00D};
        logic [1:0]  t_size  [3] = '{2'b00, 2'b01, 2'b10};
        logic [3:0]  t_be    [3] = '{4'b0010, 4'b1100, 4'b1111};
        logic [31:0] t_wdata [3] = '{32'hA5A5_A5A5, 32'h7E81_7E81, 32'hCAFE_F00D};
        logic [31:0] t_wadr  [3] = '{32'h2000, 32'h2004, 32'h2004};
        for (int i = 0; i < 3; i++) begin
            valid_in = 1; mem_write = 1; rz = t_adr[i]; rm = t_rm[i]; mem_size = t_size[i];
            tick();
            valid_in = 0; mem_write = 0;
            $display("store size=%0d @%h: be=%b wdata=%h", t_size[i], t_adr[i], bus.mem_be, bus.mem_wdata);
            n_cmp++;
            if ({bus.mem_we, bus.mem_be, bus.mem_adr, bus.mem_wdata} !== {1'b1, t_be[i], t_wadr[i], t_wdata[i]}) begin
                n_err++; $display("FAIL st_tbl%0d: got %b %b %h %h expected 1 %b %h %h", i,
                                  bus.mem_we, bus.mem_be, bus.mem_adr, bus.mem_wdata,
                                  t_be[i], t_wadr[i], t_wdata[i]);
            end
            bus.mem_gnt = 1;
            tick();
            bus.mem_gnt = 0;
            n_cmp++;
            if (done !== 1'b1 || ry !== 32'h200) begin
                n_err++; $display("FAIL st_tbl%0d_done: got %b ry=%h expected 1 ry=00000200", i, done, ry);
            end
        end
        tick();
    endtask

    task automatic test_misalign();
        logic [31:0] m_adr  [4] = '{32'h3001, 32'h3003, 32'h3000, 32'h3002};
        logic [1:0]  m_size [4] = '{2'b10, 2'b01, 2'b11, 2'b10};
        for (int i = 0; i < 4; i++) begin
            valid_in = 1; mem_read = 1; rz = m_adr[i]; mem_size = m_size[i]; y_sel = 2'd1;
            tick();
            valid_in = 0; mem_read = 0;
            $display("misaligned size=%0d @%h: err=%b", m_size[i], m_adr[i], misalign_err);
            n_cmp++;
            if ({misalign_err, done, bus.mem_req, ry_valid, ready_out} !== 5'b11001 || ry !== 32'h200) begin
                n_err++; $display("FAIL mis%0d: got %b ry=%h expected 11001 ry=00000200", i,
                                  {misalign_err, done, bus.mem_req, ry_valid, ready_out}, ry);
            end
            tick();
            n_cmp++;
            if ({misalign_err, done, bus.mem_req} !== 3'b000) begin
                n_err++; $display("FAIL mis%0d_pulse: got %b expected 000", i,
                                  {misalign_err, done, bus.mem_req});
            end
        end
    endtask

    task automatic test_timeout();
        valid_in = 1; mem_read = 1; rz = 32'h5000; mem_size = 2'b10; y_sel = 2'd1;
        tick();
        valid_in = 0; mem_read = 0;
        for (int k = 2; k <= 4; k++) begin
            tick();
            n_cmp++;
            if ({bus.mem_req, bus_err, done} !== 3'b100) begin
                n_err++; $display("FAIL to_req_cycle%0d: got %b expected 100", k, {bus.mem_req, bus_err, done});
            end
        end
        tick();
        $display("timeout: req=%b bus_err=%b done=%b", bus.mem_req, bus_err, done);
        n_cmp++;
        if ({bus.mem_req, bus_err, done, ry_valid, ready_out} !== 5'b01101 || ry !== 32'h200) begin
            n_err++; $display("FAIL to_err: got %b ry=%h expected 01101 ry=00000200",
                              {bus.mem_req, bus_err, done, ry_valid, ready_out}, ry);
        end
        bus.mem_rvalid = 1; bus.mem_rdata = 32'hDEAD_0000;
        tick();
        bus.mem_rvalid = 0;
        n_cmp++;
        if ({ry_valid, done, bus_err} !== 3'b000 || ry !== 32'h200) begin
            n_err++; $display("FAIL to_late_rvalid: got %b ry=%h expected 000 ry=00000200",
                              {ry_valid, done, bus_err}, ry);
        end
    endtask

    task automatic test_back_to_back();
        valid_in = 1; y_sel = 2'd0; rz = 32'hA;
        tick();
        $display("back-to-back alu: ry=%h", ry);
        n_cmp++;
        if (ry !== 32'hA || {done, ready_out} !== 2'b11) begin
            n_err++; $display("FAIL b2b_alu: got %h %b expected 0000000a 11", ry, {done, ready_out});
        end
        mem_write = 1; rz = 32'h7000; rm = 32'h1357_9BDF; mem_size = 2'b10;
        tick();
        valid_in = 0; mem_write = 0;
        n_cmp++;
        if ({bus.mem_req, ready_out} !== 2'b10 || bus.mem_adr !== 32'h7000) begin
            n_err++; $display("FAIL b2b_accept: got %b adr=%h expected 10 adr=00007000",
                              {bus.mem_req, ready_out}, bus.mem_adr);
        end
        bus.mem_gnt = 1;
        tick();
        bus.mem_gnt = 0;
        n_cmp++;
        if (done !== 1'b1 || ry !== 32'hA) begin
            n_err++; $display("FAIL b2b_store_done: got %b ry=%h expected 1 ry=0000000a", done, ry);
        end
        tick();
    endtask

    task automatic test_reset_in_wait();
        valid_in = 1; mem_read = 1; rz = 32'h6000; mem_size = 2'b10; y_sel = 2'd1;
        tick();
        valid_in = 0; mem_read = 0;
        bus.mem_gnt = 1;
        tick();
        bus.mem_gnt = 0;
        rst = 1;
        tick();
        rst = 0;
        $display("reset in WAIT: ry=%h done=%b", ry, done);
        n_cmp++;
        if (ry !== 32'h0 || {ry_valid, done, misalign_err, bus_err, bus.mem_req, bus.mem_we} !== 6'b0
            || bus.mem_adr !== 32'h0 || bus.mem_be !== 4'b0 || ready_out !== 1'b1) begin
            n_err++; $display("FAIL rstwait_outputs: got ry=%h flags=%b adr=%h be=%b rdy=%b expected all 0 rdy=1",
                              ry, {ry_valid, done, misalign_err, bus_err, bus.mem_req, bus.mem_we},
                              bus.mem_adr, bus.mem_be, ready_out);
        end
        bus.mem_rvalid = 1; bus.mem_rdata = 32'h7777_7777;
        tick();
        bus.mem_rvalid = 0;
        n_cmp++;
        if ({ry_valid, done} !== 2'b00 || ry !== 32'h0) begin
            n_err++; $display("FAIL rstwait_late_rvalid: got %b ry=%h expected 00 ry=00000000",
                              {ry_valid, done}, ry);
        end
        valid_in = 1; y_sel = 2'd0; rz = 32'hCAFE;
        tick();
        valid_in = 0;
        n_cmp++;
        if (ry !== 32'hCAFE || {ry_valid, done} !== 2'b11) begin
            n_err++; $display("FAIL rstwait_next_op: got %h %b expected 0000cafe 11", ry, {ry_valid, done});
        end
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1;
        idle_inputs();
        test_reset();
        test_alu();
        test_load_byte();
        test_load_half_unsigned();
        test_load_ysel_ret();
        test_store_half();
        test_store_table();
        test_misalign();
        test_timeout();
        test_back_to_back();
        test_reset_in_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Parametrised memory-access/writeback-select stage for the RISC-V core pipeline.
- Sits between the execute stage (rz/rm) and the register-file writeback (ry).
- Adds byte/half/word loads and stores with sign/zero extension, byte enables and a req/gnt/rvalid memory handshake with stall.
- Adds misalignment detection and a bus timeout. The writeback source select is kept.

Parameters:
- XLEN, 32, datapath width; 32 or 64 only.
- TIMEOUT, 16, max cycles waiting on mem_gnt or mem_rvalid before bus error; 0 disables timeout.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- valid_in  in  1  operation presented this cycle.
- ready_out  out  1  unit can accept an operation; high only in IDLE.
- rz  in  XLEN  ALU result; effective address for memory ops.
- rm  in  XLEN  store data.
- mem_read  in  1  load op.
- mem_write  in  1  store op; mem_read and mem_write both high is illegal and treated as a load.
- mem_size  in  2  00 byte, 01 half, 10 word, 11 dword (XLEN=64 only).
- mem_unsigned  in  1  zero-extend load.
- y_sel  in  2  writeback source: 0 rz, 1 load data, 2 ret_ad, 3 zero.
- ret_ad  in  XLEN  return address.
- mem_req  out  1  memory request.
- mem_we  out  1  write request.
- mem_be  out  XLEN/8  byte enables.
- mem_adr  out  XLEN  word/dword-aligned address (low log2(XLEN/8) bits zero).
- mem_wdata  out  XLEN  store data, lane-replicated.
- mem_gnt  in  1  request accepted.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  XLEN  read data.
- ry  out  XLEN  registered writeback value.
- ry_valid  out  1  one-cycle pulse: ry updated.
- done  out  1  one-cycle pulse: operation retired (any kind, including error).
- misalign_err  out  1  one-cycle pulse.
- bus_err  out  1  one-cycle pulse.

Behaviour:
- **Reset:** rst high at a clk edge returns state to IDLE. All outputs reset to 0: ry=0, ry_valid/done/misalign_err/bus_err=0, mem_req=0, mem_we=0, mem_be=0, mem_adr=0, mem_wdata=0, timeout counter=0.
  - Reset mid-transaction abandons the op with no done pulse.
  - A late mem_rvalid arriving in IDLE is ignored.
- **States:** IDLE, REQ, WAIT.
- **IDLE, valid_in with neither mem_read nor mem_write:**
  - Next edge: ry <= mux(y_sel), ry_valid=1, done=1.
  - Stay IDLE; latency 1 cycle.
- **IDLE, valid_in with memory op — alignment check:**
  - Misaligned: half with addr[0]=1; word with addr[1:0]!=0; dword with addr[2:0]!=0; or size 11 with XLEN=32.
  - If misaligned, next edge: misalign_err=1, done=1, ry unchanged, ry_valid=0, no mem_req. Stay IDLE.
- **IDLE, valid_in with aligned memory op (capture and request):**
  - Capture addr low bits, size, unsigned, y_sel and ret_ad.
  - Drive registered mem_adr, mem_be, mem_wdata and mem_we; mem_req=1; go to REQ.
  - Store byte enables: byte = 1<<lane; half = 2'b11<<lane; word = 4'hF<<lane (XLEN=64 only); word with XLEN=32 = all ones; dword = all ones.
  - Store data: rm low byte/half/word replicated across all lanes.
  - Loads: mem_be = same lane mask as stores, mem_we=0.
- **REQ:**
  - mem_req and all request outputs held stable until mem_gnt.
  - On mem_gnt for a store: drop mem_req; done=1 next edge; ry unchanged; go to IDLE.
  - On mem_gnt for a load: drop mem_req; go to WAIT. Timeout counter clears.
  - mem_rvalid in the same cycle as mem_gnt is not accepted; data is taken in WAIT only.
- **WAIT:**
  - On mem_rvalid: extract the selected lane of mem_rdata, then sign- or zero-extend to XLEN.
  - Next edge: ry <= extended data if captured y_sel==1, else mux of captured sources. ry_valid=1, done=1; go to IDLE.
- **Timeout:**
  - Counter increments each cycle in REQ/WAIT.
  - On reaching TIMEOUT (TIMEOUT>0): mem_req=0, bus_err=1, done=1, ry unchanged; go to IDLE.
  - Counter clears on state entry.
- **Handshake and stall:**
  - valid_in is ignored while ready_out=0; upstream holds the op.
  - Back-to-back ops: a new op is accepted in the cycle after done.
- **Output regs:** ry holds its value between updates.

Test Plan:
- ALU op: valid_in, y_sel=0, rz=0x1234_5678 -> next cycle ry=0x1234_5678, ry_valid=1, done=1, mem_req=0. Repeat with y_sel=2, ret_ad=0x104 -> ry=0x104.
- Signed byte load, XLEN=32: rz=0x1003, size=00, unsigned=0; gnt after 2 cycles, rvalid 1 cycle later with rdata=0x80AA_BBCC.
  - mem_adr=0x1000, mem_be=4'b1000.
  - Result: ry=0xFFFF_FF80, one done pulse, ready_out low throughout.
- Half store: rz=0x2002, rm=0xDEAD_BEEF, size=01 -> mem_we=1, mem_be=4'b1100, mem_wdata=0xBEEF_BEEF. Held stable until gnt; done next cycle; ry unchanged.
- Misaligned word load at 0x3001 -> no mem_req, misalign_err=1 and done=1 for one cycle, ry unchanged.
- TIMEOUT=4 with gnt never asserted -> mem_req high 4 cycles then low, bus_err=1, done=1, back to IDLE. A late rvalid is ignored.
- rst asserted in WAIT -> all outputs 0 next cycle, no done. A subsequent rvalid is ignored; the next op completes normally.
